// File: rtl/write_back_unit_pkg.sv
// Shared definitions for the writeback stage: write-mode encodings and
// default widths, reused by the decode and memory stages.
package write_back_unit_pkg;

  localparam int WB_DATA_W   = 16;
  localparam int WB_ADDR_W   = 16;
  localparam int WB_REG_ID_W = 4;

  typedef enum logic [1:0] {
    WM_NOP  = 2'b00,
    WM_REG  = 2'b01,
    WM_MEM  = 2'b10,
    WM_BOTH = 2'b11
  } wmode_e;

  // True when the mode retires a value to the register file.
  function automatic logic wm_has_reg(input logic [1:0] m);
    return (m == WM_REG) || (m == WM_BOTH);
  endfunction

  // True when the mode pushes a store into the store buffer.
  function automatic logic wm_has_mem(input logic [1:0] m);
    return (m == WM_MEM) || (m == WM_BOTH);
  endfunction

endpackage

// File: rtl/write_back_unit_store_fifo.sv
// wb_store_fifo: in-order store buffer with head/tail pointers and an
// occupancy count. Optional load forwarding search is built when
// WB_STORE_FORWARD_EN is defined; otherwise ld_hit/ld_data are tied to 0.
module wb_store_fifo
  import write_back_unit_pkg::*;
#(
  parameter int DATA_W   = WB_DATA_W,
  parameter int ADDR_W   = WB_ADDR_W,
  parameter int SB_DEPTH = 4,
  localparam int PTR_W   = $clog2(SB_DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  output logic [ADDR_W-1:0] head_addr_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              ld_hit_o,
  output logic [DATA_W-1:0] ld_data_o
);

  logic [ADDR_W-1:0] addr_q [SB_DEPTH];
  logic [DATA_W-1:0] data_q [SB_DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              empty;

  assign empty = (count_q == '0);

  // Pointer/count next state; caller guarantees no push when full, pop
  // is ignored while empty.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_i) tail_d = tail_q + PTR_W'(1);
    if (pop_i && !empty) head_d = head_q + PTR_W'(1);
    case ({push_i, pop_i && !empty})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset drops any queued store.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage array is never cleared; stale entries are unreachable by count.
  always_ff @(posedge clk) begin
    if (push_i) begin
      addr_q[tail_q] <= push_addr_i;
      data_q[tail_q] <= push_data_i;
    end
  end

  assign count_o     = count_q;
  assign head_addr_o = empty ? '0 : addr_q[head_q];
  assign head_data_o = empty ? '0 : data_q[head_q];

`ifdef WB_STORE_FORWARD_EN
  // Walk valid entries oldest to youngest so the youngest match wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    ld_hit_o  = 1'b0;
    ld_data_o = '0;
    idx       = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (addr_q[idx] == ld_addr_i)) begin
        ld_hit_o  = 1'b1;
        ld_data_o = data_q[idx];
      end
    end
  end
`else
  logic unused_ld_addr;
  assign unused_ld_addr = ^ld_addr_i;
  assign ld_hit_o       = 1'b0;
  assign ld_data_o      = '0;
`endif

endmodule

// File: rtl/write_back_unit.sv
// write_back_unit: final pipeline stage. Retires register writes one cycle
// after accept and queues stores into wb_store_fifo, drained via a req/ack
// memory handshake. Optional macro: WB_STORE_FORWARD_EN (load forwarding).
module write_back_unit
  import write_back_unit_pkg::*;
#(
  parameter int DATA_W   = WB_DATA_W,
  parameter int ADDR_W   = WB_ADDR_W,
  parameter int REG_ID_W = WB_REG_ID_W,
  parameter int SB_DEPTH = 4,
  localparam int CNT_W   = $clog2(SB_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_write_mode,
  input  logic [REG_ID_W-1:0] in_reg_id,
  input  logic [ADDR_W-1:0]   in_mem_addr,
  input  logic [DATA_W-1:0]   in_value,
  output logic                reg_wr_en,
  output logic [REG_ID_W-1:0] reg_id,
  output logic [DATA_W-1:0]   reg_data,
  output logic                mem_wr_req,
  input  logic                mem_wr_ack,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_data,
  input  logic [ADDR_W-1:0]   ld_addr,
  output logic                ld_hit,
  output logic [DATA_W-1:0]   ld_data,
  output logic [CNT_W-1:0]    sb_count
);

  logic                accept, push, pop;
  logic                wr_en_q, wr_en_d;
  logic [REG_ID_W-1:0] id_q, id_d;
  logic [DATA_W-1:0]   data_q, data_d;

  // Ready depends only on the registered count, never on this cycle's ack.
  assign in_ready   = (sb_count < CNT_W'(SB_DEPTH));
  assign accept     = in_valid && in_ready;
  assign push       = accept && wm_has_mem(in_write_mode);
  assign mem_wr_req = (sb_count != '0);
  assign pop        = mem_wr_req && mem_wr_ack;

  // Register-write next state: strobe for one cycle, id/data hold otherwise.
  always_comb begin
    wr_en_d = 1'b0;
    id_d    = id_q;
    data_d  = data_q;
    if (accept && wm_has_reg(in_write_mode)) begin
      wr_en_d = 1'b1;
      id_d    = in_reg_id;
      data_d  = in_value;
    end
  end

  // Register-file write port registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q <= 1'b0;
      id_q    <= '0;
      data_q  <= '0;
    end else begin
      wr_en_q <= wr_en_d;
      id_q    <= id_d;
      data_q  <= data_d;
    end
  end

  assign reg_wr_en = wr_en_q;
  assign reg_id    = id_q;
  assign reg_data  = data_q;

  wb_store_fifo #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .SB_DEPTH (SB_DEPTH)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_addr_i (in_mem_addr),
    .push_data_i (in_value),
    .pop_i       (pop),
    .ld_addr_i   (ld_addr),
    .head_addr_o (mem_addr),
    .head_data_o (mem_data),
    .count_o     (sb_count),
    .ld_hit_o    (ld_hit),
    .ld_data_o   (ld_data)
  );

endmodule

// File: tb/tb_write_back_unit.sv
// Self-checking bench for write_back_unit: directed scenarios followed by
// random traffic, checked against a queue-based reference model.
module tb_write_back_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_write_mode;
  logic [3:0]  in_reg_id;
  logic [15:0] in_mem_addr;
  logic [15:0] in_value;
  logic        reg_wr_en;
  logic [3:0]  reg_id;
  logic [15:0] reg_data;
  logic        mem_wr_req;
  logic        mem_wr_ack;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic [15:0] ld_addr;
  logic        ld_hit;
  logic [15:0] ld_data;
  logic [2:0]  sb_count;

  write_back_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_write_mode(in_write_mode), .in_reg_id(in_reg_id),
    .in_mem_addr(in_mem_addr), .in_value(in_value),
    .reg_wr_en(reg_wr_en), .reg_id(reg_id), .reg_data(reg_data),
    .mem_wr_req(mem_wr_req), .mem_wr_ack(mem_wr_ack),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
    .sb_count(sb_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: store buffer as a queue of {addr,data}, plus the
  // expected register-write port.
  logic [31:0] mq[$];
  logic        e_wr_en;
  logic [3:0]  e_id;
  logic [15:0] e_data;
  logic [15:0] popped[$];   // addresses seen by memory, in order
  logic [15:0] pushed[$];   // addresses accepted as stores, in order

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Compare all outputs with the model for the current (post-drive) state.
  task automatic check_all();
    logic        h;
    logic [15:0] d;
    h = 1'b0;
    d = '0;
`ifdef WB_STORE_FORWARD_EN
    foreach (mq[i]) if (mq[i][31:16] == ld_addr) begin h = 1'b1; d = mq[i][15:0]; end
`endif
    chk("reg_wr_en", reg_wr_en, e_wr_en);
    chk("reg_id", reg_id, e_id);
    chk("reg_data", reg_data, e_data);
    chk("sb_count", sb_count, mq.size());
    chk("in_ready", in_ready, mq.size() < DEPTH);
    chk("mem_wr_req", mem_wr_req, mq.size() != 0);
    chk("mem_addr", mem_addr, mq.size() != 0 ? mq[0][31:16] : 16'h0);
    chk("mem_data", mem_data, mq.size() != 0 ? mq[0][15:0] : 16'h0);
    chk("ld_hit", ld_hit, h);
    chk("ld_data", ld_data, d);
  endtask

  // One clock: drive inputs at negedge, check, then advance model at posedge.
  task automatic cycle(input logic r, input logic v, input logic [1:0] m,
                       input logic [3:0] id, input logic [15:0] a,
                       input logic [15:0] val, input logic ack,
                       input logic [15:0] la);
    logic acc;
    rst = r; in_valid = v; in_write_mode = m; in_reg_id = id;
    in_mem_addr = a; in_value = val; mem_wr_ack = ack; ld_addr = la;
    #1;
    check_all();
    @(posedge clk);
    if (r) begin
      mq.delete();
      e_wr_en = 1'b0; e_id = '0; e_data = '0;
    end else begin
      acc = v && (mq.size() < DEPTH);
      if (ack && mq.size() != 0) begin
        popped.push_back(mq[0][31:16]);
        void'(mq.pop_front());
      end
      if (acc && m[1]) begin
        mq.push_back({a, val});
        pushed.push_back(a);
      end
      e_wr_en = acc && m[0];
      if (e_wr_en) begin e_id = id; e_data = val; end
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic ack);
    cycle(1'b0, 1'b0, 2'b00, 4'h0, 16'h0, 16'h0, ack, 16'h0);
  endtask

  initial begin
    e_wr_en = 1'b0; e_id = '0; e_data = '0;
    @(negedge clk);
    // Reset
    cycle(1'b1, 1'b0, 2'b00, 4'h0, 16'h0, 16'h0, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 2'b00, 4'h0, 16'h0, 16'h0, 1'b0, 16'h0);
    idle(1'b0);
    // Register-only write
    cycle(1'b0, 1'b1, 2'b01, 4'h3, 16'h0, 16'hBEEF, 1'b0, 16'h0);
    chk("reg_wr_en_strobe", reg_wr_en, 1'b1);
    chk("reg_data_beef", reg_data, 16'hBEEF);
    idle(1'b0);
    idle(1'b0);
    // Reg+mem with ack tied high
    cycle(1'b0, 1'b1, 2'b11, 4'h5, 16'h0100, 16'h1234, 1'b1, 16'h0);
    idle(1'b1);
    idle(1'b1);
    // Fill with ack low, fifth op stalls, then drain
    for (int i = 0; i < 5; i++)
      cycle(1'b0, 1'b1, 2'b10, 4'h0, 16'(i), 16'(16'hA0 + i), 1'b0, 16'h0);
    chk("full_count", sb_count, 3'd4);
    cycle(1'b0, 1'b1, 2'b10, 4'h0, 16'h4, 16'hA4, 1'b1, 16'h0);
    cycle(1'b0, 1'b1, 2'b10, 4'h0, 16'h4, 16'hA4, 1'b1, 16'h0);
    for (int i = 0; i < 6; i++) idle(1'b1);
    // Steady push+pop, wraps pointers
    for (int i = 0; i < 10; i++)
      cycle(1'b0, 1'b1, 2'b10, 4'h0, 16'(16'h20 + i), 16'(i), 1'b1, 16'h0);
    idle(1'b1);
    idle(1'b1);
    // Forwarding: two stores to the same address, youngest wins
    cycle(1'b0, 1'b1, 2'b10, 4'h0, 16'h0040, 16'h0011, 1'b0, 16'h0040);
    cycle(1'b0, 1'b1, 2'b10, 4'h0, 16'h0040, 16'h0022, 1'b0, 16'h0040);
    cycle(1'b0, 1'b1, 2'b10, 4'h0, 16'h0041, 16'h0033, 1'b0, 16'h0040);
    idle(1'b0);
    // Reset with three stores queued
    cycle(1'b1, 1'b1, 2'b11, 4'h7, 16'h0050, 16'h5555, 1'b0, 16'h0040);
    chk("rst_count", sb_count, 3'd0);
    idle(1'b0);
    // Random traffic with occasional reset
    for (int n = 0; n < 400; n++) begin
      logic [15:0] ra;
      ra = 16'(16'h40 + $urandom_range(0, 3));
      cycle($urandom_range(0, 60) == 0, $urandom_range(0, 3) != 0,
            2'($urandom), 4'($urandom), ra, 16'($urandom),
            $urandom_range(0, 2) == 0, 16'(16'h40 + $urandom_range(0, 3)));
    end
    // Drain and confirm strict program order end-to-end since last reset
    for (int i = 0; i < 6; i++) idle(1'b1);
    chk("drained", sb_count, 3'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Order check independent of head-entry comparisons: every popped address
  // must match the next accepted store address (queues cleared on reset).
  always @(negedge clk) begin
    if (rst) begin
      pushed.delete();
      popped.delete();
    end
    while (popped.size() != 0 && pushed.size() != 0) begin
      chk("drain_order", popped[0], pushed[0]);
      void'(popped.pop_front());
      void'(pushed.pop_front());
    end
  end

endmodule
